// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD subtractor.
// Imported by the sequencer and the single-digit stage.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } sub_state_t;

    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] dig);
        return dig <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract with borrow in/out.
// A borrow folds the wrapped binary result back into 0..9 by subtracting 6.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [DIGIT_W:0] t;

    always_comb begin
        t    = {1'b0, x} + {1'b1, ~y} + 5'd1 - {4'd0, bin};
        bout = t[DIGIT_W];
        d    = bout ? (t[DIGIT_W-1:0] - 4'd6) : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_sub_sequencer.sv
// Sequences one shared digit stage LSD..MSD for A - B, then a second
// pass that turns a 10's-complement result into sign-magnitude.
module bcd_sub_sequencer
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DIGIT_W*N_DIGITS-1:0] a,
    input  logic [DIGIT_W*N_DIGITS-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*N_DIGITS-1:0] diff,
    output logic                        neg,
    output logic                        err
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    sub_state_t                  state;
    logic [IDX_W-1:0]            idx;
    logic                        borrow;
    logic [DIGIT_W*N_DIGITS-1:0] a_r;
    logic [DIGIT_W*N_DIGITS-1:0] b_r;

    logic [DIGIT_W-1:0] x;
    logic [DIGIT_W-1:0] y;
    logic [DIGIT_W-1:0] d;
    logic               bout;
    logic               all_bcd;
    logic               last;

    always_comb begin
        all_bcd = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_bcd_digit(a[i*DIGIT_W +: DIGIT_W]) ||
                !is_bcd_digit(b[i*DIGIT_W +: DIGIT_W]))
                all_bcd = 1'b0;
        end
    end

    // NEG pass computes 0 - diff in place, so diff feeds back as subtrahend.
    always_comb begin
        x = '0;
        y = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                x = (state == NEG) ? '0 : a_r[i*DIGIT_W +: DIGIT_W];
                y = (state == NEG) ? diff[i*DIGIT_W +: DIGIT_W]
                                   : b_r[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign last = (idx == LAST_IDX);

    bcd_digit_sub u_digit (
        .x    (x),
        .y    (y),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            borrow <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        diff   <= '0;
                        neg    <= 1'b0;
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy   <= 1'b1;
                        if (!all_bcd) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= SUB;
                        end
                    end
                end
                SUB, NEG: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (idx == IDX_W'(i))
                            diff[i*DIGIT_W +: DIGIT_W] <= d;
                    end
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        if (state == SUB && bout) begin
                            state <= NEG;
                        end else begin
                            if (state == NEG)
                                neg <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= bout;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
